// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and a busy/done handshake.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_MULT  = 4'b0001,
        OP_MULTU = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_DIVU  = 4'b0100,
        OP_MTHI  = 4'b0101,
        OP_MTLO  = 4'b0110,
        OP_MADD  = 4'b0111,
        OP_MADDU = 4'b1000,
        OP_MSUB  = 4'b1001,
        OP_MSUBU = 4'b1010
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_mul;
    logic                 is_div;
    logic [2*WIDTH-1:0]   res;

    logic signed [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic signed [WIDTH-1:0]   sa, sb_safe, sq, sr;
    logic [WIDTH-1:0]          ub_safe, uq, ur;
    logic                      div_zero, div_ovf;
`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0]        acc;
`endif

    // Full result is formed at accept from the live inputs and parked in pend_q until commit.
    always_comb begin
        ext_a_s  = {{WIDTH{A[WIDTH-1]}}, A};
        ext_b_s  = {{WIDTH{B[WIDTH-1]}}, B};
        prod_s   = ext_a_s * ext_b_s;
        prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

        div_zero = (B == '0);
        div_ovf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        sa       = A;
        sb_safe  = (div_zero || div_ovf) ? WIDTH'(1) : B;
        sq       = sa / sb_safe;
        sr       = sa % sb_safe;
        ub_safe  = div_zero ? WIDTH'(1) : B;
        uq       = A / ub_safe;
        ur       = A % ub_safe;
`ifdef MDU_MADD_EN
        acc      = {hi_q, lo_q};
`endif

        is_mul = 1'b0;
        is_div = 1'b0;
        res    = '0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; res = prod_s; end
            OP_MULTU: begin is_mul = 1'b1; res = prod_u; end
            OP_DIV: begin
                is_div = 1'b1;
                if (div_zero)     res = {A, {WIDTH{1'b1}}};
                else if (div_ovf) res = {{WIDTH{1'b0}}, A};
                else              res = {sr, sq};
            end
            OP_DIVU: begin
                is_div = 1'b1;
                if (div_zero) res = {A, {WIDTH{1'b1}}};
                else          res = {ur, uq};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; res = acc + prod_s; end
            OP_MADDU: begin is_mul = 1'b1; res = acc + prod_u; end
            OP_MSUB:  begin is_mul = 1'b1; res = acc - prod_s; end
            OP_MSUBU: begin is_mul = 1'b1; res = acc - prod_u; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_d = MUL_RUN;
                        cnt_d   = MUL_LOAD;
                        pend_d  = res;
                    end else if (is_div) begin
                        state_d = DIV_RUN;
                        cnt_d   = DIV_LOAD;
                        pend_d  = res;
                    end else if (op == OP_MTHI) begin
                        hi_d = A;
                    end else if (op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    {hi_d, lo_d} = pend_q;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
